// File: rtl/time_of_day_counter.sv
// ============================================================================
// time_of_day_counter
// ----------------------------------------------------------------------------
// Wall-clock time-of-day keeper. A prescaler divides the system clock down to
// a 1 s advance. Each advance increments a binary seconds/minutes/hours chain
// (0..59 / 0..59 / 0..23). A set mode halts counting and lets an operator bump
// one field at a time with modulo wrap and no carry.
//
// Parameters
//   DIV        clk cycles per 1 s advance (legal 2 .. 2**27)
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst_h      synchronous active-high reset
//   run        1 = timekeeping advances, 0 = time and prescaler frozen
//   set_en     1 = set mode: counting halted, prescaler cleared, edits enabled
//   set_sel    field to edit: 0 = sec, 1 = min, 2 = hour, 3 = none
//   set_inc    one increment of the selected field per high cycle (set mode)
//   sec        seconds, binary 0..59
//   min        minutes, binary 0..59
//   hour       hours, binary 0..23
//   tick       one-cycle pulse following each 1 s advance
//   day_carry  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
//
// Optional feature (macro TWELVE_HOUR_EN)
//   When defined, adds combinational outputs derived from hour:
//   hour12     12-hour display value, 1..12
//   pm         0 = AM (hours 0..11), 1 = PM (hours 12..23)
//   The 24-hour counting chain and day_carry timing are identical either way.
// ============================================================================
module time_of_day_counter #(
  parameter int unsigned DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_h,
  input  logic       run,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       tick,
  output logic       day_carry
`ifdef TWELVE_HOUR_EN
  ,
  output logic [3:0] hour12,
  output logic       pm
`endif
);

  // --------------------------------------------------------------------------
  // Constants and types
  // --------------------------------------------------------------------------
  localparam int unsigned      PW         = $clog2(DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);

  localparam logic [5:0] SEC_LAST  = 6'd59;
  localparam logic [5:0] MIN_LAST  = 6'd59;
  localparam logic [4:0] HOUR_LAST = 5'd23;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HOUR = 2'd2,
    SEL_NONE = 2'd3
  } sel_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q,   sec_d;
  logic [5:0]    min_q,   min_d;
  logic [4:0]    hour_q,  hour_d;
  logic          tick_q,  tick_d;
  logic          day_carry_q, day_carry_d;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic count_en;
  logic advance;
  logic sec_last;
  logic min_last;
  logic hour_last;
  sel_e sel;

  assign count_en = run & ~set_en;
  assign advance  = count_en & (presc_q == PRESC_LAST);

  // ">=" rather than "==" so a field can never sit past its limit: any value
  // at or beyond the last legal one wraps to 0 on its next increment.
  assign sec_last  = (sec_q  >= SEC_LAST);
  assign min_last  = (min_q  >= MIN_LAST);
  assign hour_last = (hour_q >= HOUR_LAST);

  assign sel = sel_e'(set_sel);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    presc_d     = presc_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    tick_d      = 1'b0;
    day_carry_d = 1'b0;

    // Prescaler: cleared throughout set mode so that leaving set mode always
    // starts a full DIV-cycle interval; frozen when run is low.
    if (set_en) begin
      presc_d = '0;
    end else if (count_en) begin
      presc_d = advance ? '0 : presc_q + 1'b1;
    end

    if (advance) begin
      // 1 s advance with ripple carry through the chain, all on one edge.
      tick_d = 1'b1;
      sec_d  = sec_last ? 6'd0 : sec_q + 6'd1;
      if (sec_last) begin
        min_d = min_last ? 6'd0 : min_q + 6'd1;
        if (min_last) begin
          hour_d = hour_last ? 5'd0 : hour_q + 5'd1;
        end
      end
      day_carry_d = sec_last & min_last & hour_last;
    end else if (set_en && set_inc) begin
      // Manual edit: only the selected field moves, wrapping without carry.
      case (sel)
        SEL_SEC:  sec_d  = sec_last  ? 6'd0 : sec_q  + 6'd1;
        SEL_MIN:  min_d  = min_last  ? 6'd0 : min_q  + 6'd1;
        SEL_HOUR: hour_d = hour_last ? 5'd0 : hour_q + 5'd1;
        SEL_NONE: ;
        default:  ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge and wins over every other
    // input, including a coincident advance or edit, so no pulse escapes.
    if (rst_h) begin
      presc_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      tick_q      <= 1'b0;
      day_carry_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      tick_q      <= tick_d;
      day_carry_q <= day_carry_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign tick      = tick_q;
  assign day_carry = day_carry_q;

`ifdef TWELVE_HOUR_EN
  // 12-hour view: 0 -> 12 AM, 1..11 -> AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
  logic [4:0] hour_pm;

  assign hour_pm = hour_q - 5'd12;

  always_comb begin
    pm = (hour_q >= 5'd12);
    if (hour_q == 5'd0) begin
      hour12 = 4'd12;
    end else if (hour_q > 5'd12) begin
      hour12 = hour_pm[3:0];
    end else begin
      hour12 = hour_q[3:0];
    end
  end
`endif

endmodule

// File: doc/time_of_day_counter.md
TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

Interface
REQ-001 Parameter: DIV, default 100000000, clk cycles per 1 s tick (legal 2..2^27).
REQ-002 Port: clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst_h  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: run  in  1  1 = timekeeping advances; 0 = time frozen, prescaler holds.
REQ-005 Port: set_en  in  1  1 = set mode; counting halted, manual edits enabled.
REQ-006 Port: set_sel  in  2  field to edit: 0 = sec, 1 = min, 2 = hour, 3 = none.
REQ-007 Port: set_inc  in  1  pre-debounced, one increment of the selected field per high cycle.
REQ-008 Port: sec  out  6  seconds, binary 0..59.
REQ-009 Port: min  out  6  minutes, binary 0..59.
REQ-010 Port: hour  out  5  hours, binary 0..23.
REQ-011 Port: tick  out  1  one-cycle pulse on each 1 s advance; feeds the seconds display blink.
REQ-012 Port: day_carry  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover; drives the add input of the downstream day counter.

Function
REQ-013 The prescaler SHALL count 0..DIV-1 while run=1 and set_en=0, and wrap to 0.
REQ-014 The 1 s advance condition SHALL be prescaler==DIV-1 with run=1 and set_en=0.
REQ-015 On the advance edge, tick SHALL be registered high for exactly that following cycle and sec SHALL increment.
REQ-016 At sec==59, sec SHALL wrap to 0 and min SHALL increment in the same edge; min==59 SHALL likewise carry into hour.
REQ-017 At 23:59:59, the advance SHALL produce 00:00:00 and day_carry=1 on the same edge, for one cycle only.
REQ-018 Counting latency SHALL be exactly DIV cycles from prescaler=0 to the sec update; there is no extra pipeline stage.
REQ-019 With run=0 and set_en=0, the prescaler and all time fields SHALL hold.
REQ-020 With set_en=1, the prescaler SHALL be cleared to 0 each cycle, and tick and day_carry SHALL stay 0.
REQ-021 In set mode, set_inc=1 SHALL add 1 to the field selected by set_sel with modulo wrap (59->0, 23->0) and no carry into other fields; set_sel=3 SHALL ignore set_inc.
REQ-022 set_inc with set_en=0 SHALL be ignored.
REQ-023 After set_en falls, counting SHALL resume with a full DIV-cycle interval before the next tick.
REQ-024 Field registers SHALL never hold out-of-range values; no path loads arbitrary values.

Reset
REQ-025 With rst_h=1 at a rising clk, the block SHALL set prescaler=0, sec=0, min=0, hour=0, tick=0 and day_carry=0, overriding all other inputs.
REQ-026 Reset coincident with an advance or a set_inc SHALL yield the reset values; no pulse SHALL be emitted.
REQ-027 The first tick after rst_h deasserts SHALL occur DIV cycles after the first cycle with run=1 and set_en=0.

Configuration
REQ-028 Macro TWELVE_HOUR_EN: when defined, the block SHALL add outputs hour12 (4 bits, 1..12) and pm (1 bit), derived combinationally from hour (0->12 AM, 12->12 PM, 13..23 -> 1..11 PM). The internal 0..23 counting and day_carry timing SHALL be unchanged. When undefined, these ports and this logic SHALL be absent.

Verification (bench DIV=4)
REQ-029 Reset, run=1 for 12 cycles -> tick pulses at cycles 4, 8 and 12; sec=3; day_carry stays 0.
REQ-030 Set to 23:59:58 via set mode, release, run 8 cycles -> 23:59:59 then 00:00:00 with day_carry=1 for exactly one cycle.
REQ-031 Set mode, set_sel=1 from min=59, set_inc for one cycle -> min=0, hour unchanged, no tick or day_carry.
REQ-032 run=0 mid-interval for 10 cycles -> outputs and prescaler frozen; resume -> tick after the remaining count.
REQ-033 rst_h asserted on the same edge as the 23:59:59 advance -> 00:00:00, day_carry=0.
REQ-034 With TWELVE_HOUR_EN, set hour to 0, 12 and 13 -> hour12/pm = 12/0, 12/1 and 1/1.
